// File: rtl/flash_adc_conv_ctrl.sv
// rtl/flash_adc_conv_ctrl.sv - conversion sequencer and averager for the 8-bit flash ADC
//
// Purpose:
//   Strobes the comparator latch, waits SETTLE_CYC cycles for the thermometer code and
//   encoder to settle, captures the encoder code, and averages 2**AVG_LOG2 captures
//   into one result delivered over a valid/ready handshake.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request one conversion (honoured only in IDLE)
//   continuous    restart automatically after each delivered result
//   code_in       binary code from the 256-to-8 encoder
//   sample_en     comparator latch strobe, one cycle per sample
//   busy          high whenever the sequencer is not idle
//   result        averaged result, keeps its last value after handshake
//   result_valid  result available, held until result_ready
//   result_ready  consumer accepts the result when valid && ready
//   start_ignored one-cycle pulse for a start seen outside IDLE
module flash_adc_conv_ctrl #(
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [DATA_W-1:0] code_in,
    output logic              sample_en,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              start_ignored
);

    // Accumulator is wide enough for 2**AVG_LOG2 full-scale codes, so it never wraps.
    localparam int ACC_W = DATA_W + AVG_LOG2;
    // One extra bit keeps the counter at least 1 bit wide when AVG_LOG2 is 0.
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRACK   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              sample_en_q, sample_en_d;
    logic              busy_q, busy_d;
    logic              start_ign_q, start_ign_d;
    logic [ACC_W-1:0]  acc_sum;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        valid_d     = valid_q;
        acc_sum     = acc_q + ACC_W'(code_in);
        start_ign_d = start && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            CAPTURE: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final sample is folded in directly so the result is ready on entry to DONE.
                    result_d = DATA_W'(acc_sum >> AVG_LOG2);
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = TRACK;
                end
            end
            DONE: begin
                // valid is always set while in DONE, so ready alone completes the handshake.
                if (result_ready) begin
                    valid_d = 1'b0;
                    if (continuous) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = TRACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        sample_en_d = (state_d == TRACK);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            settle_q    <= 8'd0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            start_ign_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            sample_en_q <= sample_en_d;
            busy_q      <= busy_d;
            start_ign_q <= start_ign_d;
        end
    end

    assign sample_en     = sample_en_q;
    assign busy          = busy_q;
    assign result        = result_q;
    assign result_valid  = valid_q;
    assign start_ignored = start_ign_q;

endmodule

// File: tb/tb_flash_adc_conv_ctrl.sv
// tb/tb_flash_adc_conv_ctrl.sv - self-checking bench for flash_adc_conv_ctrl
module tb_flash_adc_conv_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [7:0] code_in;
    logic       sample_en;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       start_ignored;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    flash_adc_conv_ctrl #(.DATA_W(8), .SETTLE_CYC(4), .AVG_LOG2(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .code_in      (code_in),
        .sample_en    (sample_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .start_ignored(start_ignored)
    );

    typedef struct {
        logic [7:0] c0, c1, c2, c3;
        int         exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion from IDLE and feeds one code per sample; returns edges from the
    // start-sampling edge to result_valid, a bitmap of edges after which sample_en was high,
    // and whether start_ignored was ever seen.
    task automatic conv(input logic [7:0] c0, c1, c2, c3, input bit with_cont,
                        output int lat, output int mask, output int ign);
        logic [7:0] cs[4];
        int idx;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        idx = 0; mask = 0; ign = 0; lat = -1;
        code_in    = c0;
        start      = 1'b1;
        continuous = with_cont;
        step();
        start      = 1'b0;
        continuous = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (start_ignored) ign = 1;
            if (result_valid) begin
                lat = k;
                break;
            end
            if (sample_en) begin
                if (idx < 4) code_in = cs[idx];
                idx++;
                if (k < 31) mask |= (1 << k);
            end
            step();
        end
    endtask

    task automatic handshake(input string name);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({name, " valid after handshake"}, int'(result_valid), 0);
        chk({name, " busy after handshake"}, int'(busy), 0);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int k = 0; k < max; k++) begin
            if (result_valid) begin
                n = k;
                break;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, mask, ign, n, stable, t_rise1, t_rise2;

        vecs[0] = '{8'd100, 8'd100, 8'd100, 8'd100, 100};
        vecs[1] = '{8'd10,  8'd11,  8'd12,  8'd13,  11};
        vecs[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 255};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   0};
        vecs[4] = '{8'd1,   8'd2,   8'd0,   8'd0,   0};
        vecs[5] = '{8'd3,   8'd3,   8'd3,   8'd4,   3};
        vecs[6] = '{8'd0,   8'd0,   8'd0,   8'd3,   0};
        vecs[7] = '{8'd200, 8'd201, 8'd202, 8'd203, 201};

        rst = 1'b1; start = 1'b0; continuous = 1'b0; code_in = 8'd0; result_ready = 1'b0;
        step();
        step();
        chk("reset sample_en", int'(sample_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset result", int'(result), 0);
        chk("reset result_valid", int'(result_valid), 0);
        chk("reset start_ignored", int'(start_ignored), 0);
        rst = 1'b0;
        step();

        // Basic timing: strobes after edges 0,6,12,18 and valid 24 edges after start.
        conv(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, lat, mask, ign);
        chk("t1 latency", lat, 24);
        chk("t1 sample_en edges", mask, 32'h0004_1041);
        chk("t1 result", int'(result), 100);
        chk("t1 start_ignored", ign, 0);
        chk("t1 busy in done", int'(busy), 1);
        handshake("t1");

        foreach (vecs[i]) begin
            conv(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, 1'b0, lat, mask, ign);
            chk($sformatf("vec%0d latency", i), lat, 24);
            chk($sformatf("vec%0d result", i), int'(result), vecs[i].exp);
            handshake($sformatf("vec%0d", i));
            chk($sformatf("vec%0d result kept", i), int'(result), vecs[i].exp);
        end

        // Backpressure: everything holds while ready is low.
        conv(8'd10, 8'd11, 8'd12, 8'd13, 1'b0, lat, mask, ign);
        stable = 1;
        repeat (10) begin
            step();
            if (!(result_valid == 1'b1 && result == 8'd11 && busy == 1'b1)) stable = 0;
        end
        chk("hold stable", stable, 1);
        handshake("hold");
        step();
        chk("hold idle after", int'(sample_en || busy), 0);

        // Continuous mode with ready tied high; a stray start mid-conversion is dropped.
        code_in = 8'd50; result_ready = 1'b1; continuous = 1'b1;
        step();
        repeat (8) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cont start_ignored pulse", int'(start_ignored), 1);
        step();
        chk("cont start_ignored clear", int'(start_ignored), 0);
        wait_valid(40, n);
        t_rise1 = (n < 0) ? -1 : 10 + n;
        chk("cont first valid edge", t_rise1, 24);
        chk("cont result", int'(result), 50);
        step();
        chk("cont valid drop", int'(result_valid), 0);
        chk("cont restart strobe", int'(sample_en), 1);
        repeat (5) step();
        continuous = 1'b0;
        wait_valid(40, n);
        t_rise2 = (n < 0) ? -1 : t_rise1 + 6 + n;
        chk("cont period", t_rise2 - t_rise1, 25);
        step();
        chk("cont drop valid", int'(result_valid), 0);
        chk("cont drop busy", int'(busy), 0);
        repeat (3) step();
        chk("cont stays idle", int'(sample_en || busy), 0);
        result_ready = 1'b0;

        // Asynchronous reset in the middle of SETTLE.
        code_in = 8'd77; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst sample_en", int'(sample_en), 0);
        chk("arst busy", int'(busy), 0);
        chk("arst result", int'(result), 0);
        chk("arst result_valid", int'(result_valid), 0);
        chk("arst start_ignored", int'(start_ignored), 0);
        step();
        rst = 1'b0;
        step();
        conv(8'd10, 8'd11, 8'd12, 8'd13, 1'b0, lat, mask, ign);
        chk("arst fresh latency", lat, 24);
        chk("arst fresh result", int'(result), 11);
        handshake("arst");

        // start and continuous together in IDLE: one conversion, no ignored pulse.
        conv(8'd40, 8'd41, 8'd42, 8'd43, 1'b1, lat, mask, ign);
        chk("both latency", lat, 24);
        chk("both result", int'(result), 41);
        chk("both start_ignored", ign, 0);
        handshake("both");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
